vga_scanout: RTL
================

Name: vga_scanout

Overview:
- Final video stage: generates 640x480@60 VGA timing from the 50 MHz master clock and drives the VGA_R/G/B/HS/VS pins.
- Consumes an RGB444 pixel stream from the upstream frame-buffer reader (SDRAM side) through a valid/ready handshake.
- Buffers the stream in a small internal FIFO.
- Pulses frame_start once per frame so the upstream reader rewinds its address.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, >=4)

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  synchronous, active-low reset
- pix_data  in  12  upstream pixel {R[3:0],G[3:0],B[3:0]}
- pix_valid  in  1  upstream pixel valid
- pix_ready  out  1  FIFO accepts pixel this cycle
- frame_start  out  1  one-clk pulse: new frame; upstream restarts at pixel (0,0)
- underflow  out  1  sticky: FIFO was empty at an active-pixel pop this frame
- pattern_sel  in  1  select internal test pattern (see Optional Feature)
- vga_r, vga_g, vga_b  out  4 each  colour outputs
- vga_hs, vga_vs  out  1 each  syncs, active low

Behaviour:
- Pixel enable ce:
  - Toggles every clk; ce=0 on the first clk after reset release.
  - All timing counters advance only when ce=1, giving 25 MHz pixels.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL=800), then wraps to 0 and increments v_cnt.
  - v_cnt runs 0..V_TOTAL-1 (V_TOTAL=525), then wraps to 0.
  - Reset values: h_cnt=0, v_cnt=V_TOTAL-1.
- Syncs and active region:
  - active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hs_n low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752).
  - vs_n low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [490,492).
- Output register:
  - vga_* is registered on ce=1 from the current counter state, so RGB, HS and VS share one stage with 1 pixel of latency.
  - RGB is 0 whenever !active.
  - Reset values: vga_hs=1, vga_vs=1, RGB=0.
- frame_start:
  - Asserted for exactly one clk when ce=1 && h_cnt==0 && v_cnt==V_TOTAL-1, which is one full blank line before line 0 and lets the FIFO prefill.
  - Reset value 0.
  - First pulse occurs on the 2nd clk after reset release.
- FIFO flush and arming:
  - On the frame_start cycle the FIFO is flushed (count=0) and an internal armed flag is set.
  - armed is cleared by reset only.
- pix_ready = armed && !full && !frame_start. Reset value 0.
- Push: a pixel is written when pix_valid && pix_ready. No push ever occurs while full.
- Pop:
  - Occurs when ce=1 && active.
  - If the FIFO is non-empty, the head drives RGB.
  - If empty, RGB=0 and underflow is set.
- Simultaneous push and pop: both performed; count unchanged. Pop of an empty FIFO with a same-cycle push still underflows; the pushed pixel is kept.
- underflow:
  - Cleared on frame_start (frame_start has priority over a set in the same cycle).
  - Reset value 0.
- Extra pixels left in the FIFO at end of frame are discarded by the next flush.
- Pointers and count: pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits. full = count==FIFO_DEPTH; empty = count==0.
- Reset mid-frame: all state returns to reset values on the next clk; the FIFO is emptied; vga_hs and vga_vs go high immediately; the frame restarts via frame_start.

Optional Feature:
- Macro: WS2_VGA_TEST_PATTERN_EN.
- Defined:
  - When pattern_sel=1, active RGB = {h_cnt[9:6], v_cnt[8:5], h_cnt[9:6]^v_cnt[8:5]}.
  - The FIFO still pops, but popped data is ignored and underflow is not set.
  - Timing is unchanged.
- Undefined: pattern_sel is ignored and the block behaves exactly as with pattern_sel=0.

Test Plan:
- Reset release, pix_valid=0 -> frame_start pulses on clk 2; HS period 1600 clk with low width 192 clk; VS period 840000 clk with low width 3200 clk.
- Upstream streams a constant 12'hF80 with pix_valid=1 -> every active pixel outputs R=F,G=8,B=0; blanking outputs 0; underflow stays 0; pix_ready deasserts when count=16.
- pix_valid=0 throughout frame -> RGB=0 on active pixels; underflow=1 from the first active pop until the next frame_start, then 0.
- Upstream supplies 640*480+5 pixels -> 5 extras are flushed at frame_start; the next frame's pixel (0,0) equals the first pixel sent after frame_start.
- Assert reset_n=0 at h=300, v=200 for 1 clk -> next clk vga_hs=1, vga_vs=1, RGB=0, pix_ready=0; frame_start 2 clk after release.
- With WS2_VGA_TEST_PATTERN_EN and pattern_sel=1, pixel (64,32) -> RGB={4'h1,4'h1,4'h0}, underflow=0 with no upstream data.

Source files
------------

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: 25 MHz pixel enable from 50 MHz clk, timing counters,
// RGB444 pixel FIFO fed by valid/ready, registered RGB/HS/VS. Optional macro: WS2_VGA_TEST_PATTERN_EN.
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_start,
  output logic        underflow,
  input  logic        pattern_sel,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int DATA_W  = 12;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW_H    = $clog2(H_TOTAL);
  localparam int CW_V    = $clog2(V_TOTAL);
  // At least 10 bits so the test pattern can always tap h[9:6] and v[8:5].
  localparam int CNT_W   = (CW_H > 10) ? ((CW_H > CW_V) ? CW_H : CW_V) : ((CW_V > 10) ? CW_V : 10);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic              ce;
  logic [CNT_W-1:0]  h_cnt_p0;
  logic [CNT_W-1:0]  v_cnt_p0;
  logic              active;
  logic              hs_on;
  logic              vs_on;
  logic              pat_on;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              armed;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop_req;
  logic              pop;

  logic [DATA_W-1:0] rgb_next;
  logic [DATA_W-1:0] rgb_p1;
  logic              hs_p1;
  logic              vs_p1;

`ifdef WS2_VGA_TEST_PATTERN_EN
  assign pat_on = pattern_sel;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pat_on = 1'b0;
`endif

  // Stage p0: pixel enable and timing counters
  always_ff @(posedge clk) begin
    if (!reset_n) ce <= 1'b0;
    else          ce <= ~ce;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= V_LAST;
    end else if (ce) begin
      if (h_cnt_p0 == H_LAST) begin
        h_cnt_p0 <= '0;
        v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + 1'b1;
      end else begin
        h_cnt_p0 <= h_cnt_p0 + 1'b1;
      end
    end
  end

  assign active      = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
  assign hs_on       = (h_cnt_p0 >= HS_BEG) && (h_cnt_p0 < HS_END);
  assign vs_on       = (v_cnt_p0 >= VS_BEG) && (v_cnt_p0 < VS_END);
  // Fires one blank line ahead of line 0 so the FIFO can prefill.
  assign frame_start = ce && (h_cnt_p0 == '0) && (v_cnt_p0 == V_LAST);

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign pix_ready = armed && !full && !frame_start;
  assign push      = pix_valid && pix_ready;
  assign pop_req   = ce && active;
  assign pop       = pop_req && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pix_data;
  end

  // frame_start never coincides with a push (ready low) or a pop (blank line).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      armed     <= 1'b0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      armed     <= 1'b1;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop_req && empty && !pat_on) underflow <= 1'b1;
    end
  end

  always_comb begin
    rgb_next = '0;
    if (active) begin
      if (!empty) rgb_next = mem[rd_ptr];
`ifdef WS2_VGA_TEST_PATTERN_EN
      if (pattern_sel)
        rgb_next = {h_cnt_p0[9:6], v_cnt_p0[8:5], h_cnt_p0[9:6] ^ v_cnt_p0[8:5]};
`endif
    end
  end

  // Stage p1: registered colour and syncs, one pixel behind the counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rgb_p1 <= '0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else if (ce) begin
      rgb_p1 <= rgb_next;
      hs_p1  <= !hs_on;
      vs_p1  <= !vs_on;
    end
  end

  assign vga_r  = rgb_p1[11:8];
  assign vga_g  = rgb_p1[7:4];
  assign vga_b  = rgb_p1[3:0];
  assign vga_hs = hs_p1;
  assign vga_vs = vs_p1;

endmodule
